// File: rtl/channel_rr_sched.sv
// ---------------------------------------------------------------------------
// channel_rr_sched
//   Round-robin scheduler sharing one cache write channel among PORTNUM
//   input ports. One port is granted per packet; the scheduler counts that
//   packet's beats against the port's length field and emits the
//   end-of-packet pulse itself. A transfer that stalls for TMO consecutive
//   idle cycles is aborted. Every packet is followed by exactly one dead
//   (GAP) cycle before the next arbitration.
//
// Ports
//   i_clk    : clock
//   i_rst_n  : asynchronous, active-low reset
//   i_req    : per-port packet request (level, held until granted)
//   i_len    : per-port packet length (beats-1), port k at [k*LENW +: LENW]
//   i_vld    : beat-valid from the granted port's datapath
//   o_grant  : one-hot grant
//   o_sel    : granted port index (qualify with o_en)
//   o_en     : channel enable, equals |o_grant
//   o_busy   : high whenever the FSM is not in IDLE
//   o_end    : one-cycle pulse, packet completed
//   o_abort  : one-cycle pulse, packet terminated by timeout
// ---------------------------------------------------------------------------
module channel_rr_sched #(
    parameter int PORTNUM = 16,
    parameter int LENW    = 6,
    parameter int TMO     = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [PORTNUM-1:0]         i_req,
    input  logic [PORTNUM*LENW-1:0]    i_len,
    input  logic                       i_vld,
    output logic [PORTNUM-1:0]         o_grant,
    output logic [$clog2(PORTNUM)-1:0] o_sel,
    output logic                       o_en,
    output logic                       o_busy,
    output logic                       o_end,
    output logic                       o_abort
);

    localparam int SELW = $clog2(PORTNUM);
    localparam int CW   = SELW + 1;
    localparam int TMOW = $clog2(TMO + 1);

    localparam logic [SELW-1:0] LAST_PORT = SELW'(PORTNUM - 1);
    localparam logic [TMOW-1:0] TMO_LAST  = TMOW'(TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PORTNUM-1:0]   grant_q, grant_d;
    logic [SELW-1:0]      sel_q,   sel_d;
    logic                 en_q,    en_d;
    logic                 busy_q,  busy_d;
    logic                 end_q,   end_d;
    logic                 abort_q, abort_d;
    logic [SELW-1:0]      ptr_q,   ptr_d;
    logic [LENW-1:0]      cnt_q,   cnt_d;
    logic [TMOW-1:0]      tmo_q,   tmo_d;
    logic [LENW-1:0]      len_q,   len_d;

    logic [LENW-1:0]      len_arr [PORTNUM];
    logic [SELW-1:0]      win;
    logic                 found;
    logic [CW-1:0]        cand;

    // Rotate the priority pointer; wraps at PORTNUM-1, not at the power of two.
    function automatic logic [SELW-1:0] next_port(input logic [SELW-1:0] p);
        return (p == LAST_PORT) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < PORTNUM; k++) begin
            len_arr[k] = i_len[k*LENW +: LENW];
        end
    end

    // Search i_req from ptr upward with wrap. The candidate carries one extra
    // bit so ptr+i never overflows before the modulo fold.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < PORTNUM; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(PORTNUM)) begin
                cand = cand - CW'(PORTNUM);
            end
            if (!found && i_req[cand[SELW-1:0]]) begin
                found = 1'b1;
                win   = cand[SELW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        en_d    = en_q;
        end_d   = 1'b0;
        abort_d = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        len_d   = len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d      = ST_XFER;
                    sel_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    en_d         = 1'b1;
                    len_d        = len_arr[win];
                    cnt_d        = '0;
                    tmo_d        = '0;
                end
            end
            ST_XFER: begin
                if (i_vld) begin
                    tmo_d = '0;
                    // Compare fires before cnt could wrap, so len=2^LENW-1 is safe.
                    if (cnt_q == len_q) begin
                        end_d   = 1'b1;
                        grant_d = '0;
                        en_d    = 1'b0;
                        ptr_d   = next_port(sel_q);
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    en_d    = 1'b0;
                    ptr_d   = next_port(sel_q);
                    state_d = ST_GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            abort_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
            abort_q <= abort_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Latched length is only consulted in XFER, after a grant has loaded it.
    always_ff @(posedge i_clk) begin
        len_q <= len_d;
    end

    assign o_grant = grant_q;
    assign o_sel   = sel_q;
    assign o_en    = en_q;
    assign o_busy  = busy_q;
    assign o_end   = end_q;
    assign o_abort = abort_q;

endmodule

// File: tb/tb_channel_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_channel_rr_sched
//   Directed bench for channel_rr_sched. Expected grant indices are queued
//   when requests are driven and popped when the scheduler raises o_en.
//   A second instance (12 ports, short timeout) covers the non-power-of-two
//   pointer wrap.
// ---------------------------------------------------------------------------
module tb_channel_rr_sched;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [95:0] len;
    logic        vld;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        en, busy, pend, pabort;

    logic [11:0] req12;
    logic [35:0] len12;
    logic        vld12;
    logic [11:0] grant12;
    logic [3:0]  sel12;
    logic        en12, busy12, end12, abort12;

    int errors = 0;
    int checks = 0;
    int sb_q[$];

    channel_rr_sched #(.PORTNUM(16), .LENW(6), .TMO(255)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_len   (len),
        .i_vld   (vld),
        .o_grant (grant),
        .o_sel   (sel),
        .o_en    (en),
        .o_busy  (busy),
        .o_end   (pend),
        .o_abort (pabort)
    );

    channel_rr_sched #(.PORTNUM(12), .LENW(3), .TMO(4)) u_dut12 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req12),
        .i_len   (len12),
        .i_vld   (vld12),
        .o_grant (grant12),
        .o_sel   (sel12),
        .o_en    (en12),
        .o_busy  (busy12),
        .o_end   (end12),
        .o_abort (abort12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int port, input logic [5:0] val);
        len[port*6 +: 6] = val;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_sel"},   32'(sel),   32'h0);
        check({tag, "_en"},    32'(en),    32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
        check({tag, "_end"},   32'(pend),  32'h0);
        check({tag, "_abort"}, 32'(pabort), 32'h0);
    endtask

    // Wait (bounded) for o_en, then compare against the scoreboard head.
    task automatic grant16(input string tag, input int exp_wait);
        int waited = 0;
        int port   = -1;
        while (en !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (sb_q.size() != 0) port = sb_q.pop_front();
        check({tag, "_en"},    32'(en),    32'h1);
        check({tag, "_sel"},   32'(sel),   32'(port));
        check({tag, "_grant"}, 32'(grant), 32'h1 << port);
        if (exp_wait > 0) check({tag, "_lat"}, 32'(waited), 32'(exp_wait));
    endtask

    task automatic grant12_chk(input string tag);
        int waited = 0;
        int port   = -1;
        while (en12 !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (sb_q.size() != 0) port = sb_q.pop_front();
        check({tag, "_en"},    32'(en12),    32'h1);
        check({tag, "_sel"},   32'(sel12),   32'(port));
        check({tag, "_grant"}, 32'(grant12), 32'h1 << port);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        req   = 16'hFFFF;
        vld   = 1'b1;
        len   = '0;
        req12 = '0;
        len12 = '0;
        vld12 = 1'b0;

        // Reset held with every request and beat-valid active.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle_outputs("rst");
        end

        // Fairness: all ports requesting, len=0, one grant every 3 cycles.
        for (int i = 0; i <= 16; i++) sb_q.push_back(i % 16);
        rst_n = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            grant16("fair", (i == 0) ? 1 : 2);
            if (i == 16) req = '0;
            tick();
            check("fair_end",   32'(pend),  32'h1);
            check("fair_clr",   32'(grant), 32'h0);
        end
        tick();
        check("fair_busy_off", 32'(busy), 32'h0);
        check("fair_end_off",  32'(pend), 32'h0);

        // Single packet on port 3, len=2; later length change is ignored.
        set_len(3, 6'd2);
        req = 16'h0008;
        vld = 1'b1;
        sb_q.push_back(3);
        grant16("single", 1);
        set_len(3, 6'd0);
        req = '0;
        for (int b = 1; b <= 2; b++) begin
            tick();
            check("single_noend", 32'(pend),  32'h0);
            check("single_hold",  32'(grant), 32'h0008);
            check("single_busy",  32'(busy),  32'h1);
        end
        tick();
        check("single_end",     32'(pend),  32'h1);
        check("single_gclr",    32'(grant), 32'h0);
        check("single_enclr",   32'(en),    32'h0);
        check("single_busygap", 32'(busy),  32'h1);
        tick();
        check("single_end1cyc", 32'(pend),  32'h0);
        check("single_busyoff", 32'(busy),  32'h0);

        // Timeout on port 5 (ptr=4), then port 6 takes over.
        set_len(5, 6'd0);
        set_len(6, 6'd63);
        req = 16'h0060;
        vld = 1'b0;
        sb_q.push_back(5);
        grant16("tmo5", 1);
        bad = 0;
        for (int k = 1; k <= 254; k++) begin
            tick();
            if (pabort !== 1'b0 || pend !== 1'b0 || en !== 1'b1) bad++;
        end
        check("tmo5_early", 32'(bad), 32'h0);
        tick();
        check("tmo5_abort", 32'(pabort), 32'h1);
        check("tmo5_noend", 32'(pend),   32'h0);
        check("tmo5_gclr",  32'(grant),  32'h0);
        sb_q.push_back(6);
        grant16("tmo_next6", 2);
        req = '0;

        // Single beat at idle cycle 200 restarts the timeout.
        bad = 0;
        for (int k = 1; k <= 199; k++) begin
            tick();
            if (pabort !== 1'b0 || en !== 1'b1) bad++;
        end
        vld = 1'b1;
        tick();
        vld = 1'b0;
        if (pabort !== 1'b0 || pend !== 1'b0) bad++;
        for (int k = 1; k <= 254; k++) begin
            tick();
            if (pabort !== 1'b0 || en !== 1'b1) bad++;
        end
        check("tmo6_early", 32'(bad), 32'h0);
        tick();
        check("tmo6_abort", 32'(pabort), 32'h1);
        check("tmo6_gclr",  32'(grant),  32'h0);
        tick();
        check("tmo6_pulse", 32'(pabort), 32'h0);
        check("tmo6_busy",  32'(busy),   32'h0);

        // Serve port 14 so ptr=15, then ports 15 and 2 compete.
        set_len(14, 6'd0);
        set_len(15, 6'd0);
        set_len(2, 6'd0);
        vld = 1'b1;
        req = 16'h4000;
        sb_q.push_back(14);
        grant16("wrap14", 1);
        req = 16'h8004;
        sb_q.push_back(15);
        sb_q.push_back(2);
        tick();
        check("wrap14_end", 32'(pend), 32'h1);
        grant16("wrap15", 2);
        req = 16'h0004;
        tick();
        grant16("wrap2", 2);
        req = '0;
        tick();
        tick();

        // Reset in the middle of a 5-beat packet on port 9.
        set_len(9, 6'd4);
        req = 16'h0200;
        sb_q.push_back(9);
        grant16("mid9", 1);
        req = 16'h0201;
        tick();
        tick();
        check("mid9_noend", 32'(pend), 32'h0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        tick();
        check("midrst_end",   32'(pend),   32'h0);
        check("midrst_abort", 32'(pabort), 32'h0);
        check("midrst_grant", 32'(grant),  32'h0);
        rst_n = 1'b1;
        sb_q.push_back(0);
        grant16("post_rst0", 1);
        req = '0;
        tick();
        tick();

        // 12-port instance: ptr wraps from 11 to 0, then a 4-cycle timeout.
        vld12 = 1'b1;
        req12 = 12'h800;
        sb_q.push_back(11);
        grant12_chk("p12_11");
        req12 = 12'h401;
        sb_q.push_back(0);
        tick();
        check("p12_end", 32'(end12), 32'h1);
        grant12_chk("p12_wrap0");
        req12 = '0;
        vld12 = 1'b0;
        bad = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (abort12 !== 1'b0) bad++;
        end
        check("p12_tmo_early", 32'(bad), 32'h0);
        tick();
        check("p12_abort", 32'(abort12), 32'h1);
        check("p12_gclr",  32'(grant12), 32'h0);
        check("p12_noend", 32'(end12),   32'h0);

        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/channel_rr_sched.md
Name: channel_rr_sched

Overview:
- Round-robin scheduler that shares one cache write channel among PORTNUM input ports.
- Grants one port per packet, counts that packet's beats against a per-port length, and generates the end-of-packet pulse itself.
- Aborts a stalled transfer after a programmable idle timeout.
- Sits between the per-port input FIFOs and the channel demux, driving its select/enable.

Parameters:
- PORTNUM, 16, number of requesting ports; 2..16; need not be a power of two.
- LENW, 6, width of the per-port length field; length encodes beats-1.
- TMO, 255, consecutive idle cycles in XFER before abort; TMO >= 1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_req  in  PORTNUM  per-port packet request; level, held until granted.
- i_len  in  PORTNUM*LENW  per-port packet length (beats-1); port k occupies bits [k*LENW +: LENW].
- i_vld  in  1  beat-valid from the granted port's datapath.
- o_grant  out  PORTNUM  one-hot grant.
- o_sel  out  $clog2(PORTNUM)  granted port index, for the demux.
- o_en  out  1  channel enable; equals |o_grant.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_end  out  1  one-cycle pulse: packet completed.
- o_abort  out  1  one-cycle pulse: packet terminated by timeout.

Behaviour:
- Reset values: state=IDLE, o_grant=0, o_sel=0, o_en=0, o_busy=0, o_end=0, o_abort=0, ptr=0, cnt=0, tmo=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Arbitration: winner = first set bit of i_req searched from index ptr upward, wrapping from PORTNUM-1 to 0. ptr is the rotating priority pointer.
- FSM states: IDLE, XFER, GAP.
- IDLE, edge with |i_req:
  - go to XFER.
  - o_sel<=winner; o_grant<=1<<winner; o_en<=1.
  - len_q<=i_len slice of winner; cnt<=0; tmo<=0.
  - Latency: request sampled at edge N gives grant visible after edge N.
- IDLE, no request: hold all outputs at 0.
- XFER, edge with i_vld=1:
  - tmo<=0.
  - If cnt==len_q: o_end<=1, o_grant<=0, o_en<=0, ptr<=(o_sel+1) mod PORTNUM, go to GAP.
  - Otherwise cnt<=cnt+1.
- XFER, edge with i_vld=0:
  - If tmo==TMO-1: o_abort<=1, o_grant<=0, o_en<=0, ptr<=(o_sel+1) mod PORTNUM, go to GAP.
  - Otherwise tmo<=tmo+1.
- GAP: o_end<=0, o_abort<=0, go to IDLE. Provides exactly one dead cycle between packets.
- o_sel holds its last value in GAP and IDLE; consumers qualify it with o_en.
- Each packet occupies len+1 beat cycles plus 2 overhead cycles (GAP, IDLE). Back-to-back len=0 packets therefore repeat every 3 cycles.
- Boundary conditions:
  - Deasserting i_req during XFER has no effect; the grant is held until end or abort.
  - i_len changes after the grant are ignored, because len_q is latched.
  - i_vld outside XFER is ignored.
  - len_q = 2^LENW-1 is legal; cnt is LENW bits wide and never wraps, because the compare fires first.
  - Beat and timeout on the same cycle cannot occur, since i_vld resets tmo; end takes precedence by construction.
  - ptr advances after both end and abort, so a stalled port cannot starve the others.
  - Asynchronous reset mid-XFER returns every register to its reset value immediately; o_end/o_abort are not emitted for the killed packet.
- Width rules: tmo counter is $clog2(TMO+1) bits. ptr and o_sel are $clog2(PORTNUM) bits. The ptr increment wraps explicitly at PORTNUM-1, not at the power of two.

Test Plan:
- Reset check: assert i_rst_n=0 with i_req=16'hFFFF and i_vld=1 -> o_grant=0, o_sel=0, o_en=0, o_busy=0, o_end=0, o_abort=0 throughout; first grant after release goes to port 0.
- Single packet: i_req[3]=1, len3=2, i_vld high from the grant -> o_grant=16'h0008, o_sel=3 one cycle after request. After the 3rd beat edge, o_end=1 for one cycle and o_grant=0 on that same edge. o_busy drops one cycle later.
- Fairness: i_req=16'hFFFF held, all len=0, i_vld=1 -> grants 0,1,2,...,15,0 in order, one grant every 3 cycles, never the same port twice in a row.
- Timeout: port 5 granted, i_vld=0 for 255 cycles -> o_abort pulse on the 255th idle edge, o_grant cleared, o_end never asserted. With i_req[6]=1, the next grant goes to port 6. Repeat with one i_vld at idle cycle 200 -> abort delayed to 255 cycles after that beat.
- Wrap and priority: serve port 14 so ptr=15, then i_req = bits 2 and 15 -> port 15 granted first, then port 2. With PORTNUM=12, serving port 11 wraps ptr to 0.
- Reset mid-transfer: assert reset during XFER of port 9 after 2 of 5 beats -> all outputs 0 at once, no o_end/o_abort. After release, ptr=0 and port 0 wins if requesting.
